// File: rtl/hog_cell_histogram.sv
// hog_cell_histogram: bins gradient vectors by unsigned orientation and accumulates magnitude per cell.
// Completed cells are streamed out while the next cell accumulates.
module hog_cell_histogram #(
  parameter int NUM_BINS = 4,
  parameter int CELL_SIZE = 64,
  parameter int ACC_W = 24
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      direction_valid_in,
  input  logic [31:0]               direction,
  input  logic [15:0]               magnitude,
  output logic                      aggregator_ready,
  output logic [NUM_BINS*ACC_W-1:0] mag_bins,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [15:0]               cell_count
);
  localparam int BW = $clog2(NUM_BINS);
  localparam int NT = NUM_BINS / 2;
  if (NUM_BINS != 4 && NUM_BINS != 8) begin : g_bad_bins
    $error("NUM_BINS must be 4 or 8");
  end
  function automatic int thr(input int j);
    return NUM_BINS == 4 ? (j == 0 ? 106 : 618)
                         : (j == 0 ? 51 : j == 1 ? 171 : j == 2 ? 383 : 1287);
  endfunction
  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    return v == 16'h8000 ? 16'h7FFF : -v;
  endfunction
  logic                      ready_q, s1_v_q, s1_last_q, s1_s_q, s2_v_q, s2_last_q, done_q, tvalid_q;
  logic [15:0]               cnt_q, cells_q, s1_a_q, s1_b_q, s1_m_q, s2_m_q;
  logic [BW-1:0]             s2_bin_q;
  logic [NUM_BINS*ACC_W-1:0] acc_q, bins_q;
  logic                      flip, hs, last, xfer;
  logic [15:0]               fx, fy, a_d;
  logic [2:0]                k;
  logic [BW-1:0]             bin_d;
  logic [ACC_W:0]            sum;
  logic [ACC_W-1:0]          acc_add;
  // Fold into the upper half-plane so the angle is in 0..180 degrees.
  always_comb begin
    flip = direction[15] || (direction[15:0] == '0 && direction[31]);
    fx = flip ? neg_sat(direction[31:16]) : direction[31:16];
    fy = flip ? neg_sat(direction[15:0]) : direction[15:0];
    a_d = fx[15] ? -fx : fx;
  end
  always_comb begin
    k = '0;
    for (int j = 0; j < NT; j++)
      if ({4'd0, s1_b_q, 8'd0} >= 28'(thr(j)) * 28'(s1_a_q)) k = k + 3'd1;
    bin_d = (s1_a_q == '0 && s1_b_q == '0) ? '0 : s1_s_q ? BW'(NUM_BINS - int'(k)) : BW'(k);
  end
  always_comb begin
    hs = direction_valid_in && ready_q;
    last = hs && cnt_q == 16'(CELL_SIZE - 1);
    xfer = done_q && (!tvalid_q || m_axis_tready);
    sum = {1'b0, acc_q[s2_bin_q*ACC_W +: ACC_W]} + (ACC_W+1)'(s2_m_q);
    acc_add = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ready_q <= 1'b1;
      s1_v_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_s_q <= 1'b0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      s1_m_q <= '0;
      s2_v_q <= 1'b0;
      s2_last_q <= 1'b0;
      s2_bin_q <= '0;
      s2_m_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      tvalid_q <= 1'b0;
      bins_q <= '0;
      cells_q <= '0;
      acc_q <= '0;
    end else begin
      s1_v_q <= hs;
      if (hs) begin
        s1_last_q <= last;
        s1_s_q <= fx[15];
        s1_a_q <= a_d;
        s1_b_q <= fy;
        s1_m_q <= magnitude;
        cnt_q <= last ? '0 : cnt_q + 16'd1;
      end
      s2_v_q <= s1_v_q;
      s2_last_q <= s1_v_q && s1_last_q;
      s2_bin_q <= bin_d;
      s2_m_q <= s1_m_q;
      ready_q <= xfer ? 1'b1 : last ? 1'b0 : ready_q;
      done_q <= xfer ? 1'b0 : (s2_v_q && s2_last_q) ? 1'b1 : done_q;
      tvalid_q <= xfer ? 1'b1 : m_axis_tready ? 1'b0 : tvalid_q;
      if (xfer) begin
        bins_q <= acc_q;
        cells_q <= cells_q + 16'd1;
        acc_q <= '0;
      end else if (s2_v_q) begin
        acc_q[s2_bin_q*ACC_W +: ACC_W] <= acc_add;
      end
    end
  end
  assign aggregator_ready = ready_q;
  assign mag_bins = bins_q;
  assign m_axis_tvalid = tvalid_q;
  assign cell_count = cells_q;
endmodule

// File: tb/tb_hog_cell_histogram.sv
// tb_hog_cell_histogram: directed checks of timing, orientation binning, backpressure, saturation and reset.
module tb_hog_cell_histogram;
  logic         clk_in, rst_in, tready;
  logic [31:0]  dir;
  logic [15:0]  mag;
  logic         v0, v1, v2, v3, v4;
  logic         r0, r1, r2, r3, r4, t0, t1, t2, t3, t4;
  logic [95:0]  b0, b1, b3;
  logic [191:0] b2;
  logic [67:0]  b4;
  logic [15:0]  c0, c1, c2, c3, c4;
  int           n_cmp, n_err;
  logic [31:0]  sw_dir [8];
  int           sw_bin [8];

  hog_cell_histogram #(.NUM_BINS(4), .CELL_SIZE(4), .ACC_W(24)) u0 (
    .clk_in(clk_in), .rst_in(rst_in), .direction_valid_in(v0), .direction(dir), .magnitude(mag),
    .aggregator_ready(r0), .mag_bins(b0), .m_axis_tvalid(t0), .m_axis_tready(tready), .cell_count(c0));
  hog_cell_histogram #(.NUM_BINS(4), .CELL_SIZE(1), .ACC_W(24)) u1 (
    .clk_in(clk_in), .rst_in(rst_in), .direction_valid_in(v1), .direction(dir), .magnitude(mag),
    .aggregator_ready(r1), .mag_bins(b1), .m_axis_tvalid(t1), .m_axis_tready(tready), .cell_count(c1));
  hog_cell_histogram #(.NUM_BINS(8), .CELL_SIZE(1), .ACC_W(24)) u2 (
    .clk_in(clk_in), .rst_in(rst_in), .direction_valid_in(v2), .direction(dir), .magnitude(mag),
    .aggregator_ready(r2), .mag_bins(b2), .m_axis_tvalid(t2), .m_axis_tready(tready), .cell_count(c2));
  hog_cell_histogram #(.NUM_BINS(4), .CELL_SIZE(2), .ACC_W(24)) u3 (
    .clk_in(clk_in), .rst_in(rst_in), .direction_valid_in(v3), .direction(dir), .magnitude(mag),
    .aggregator_ready(r3), .mag_bins(b3), .m_axis_tvalid(t3), .m_axis_tready(tready), .cell_count(c3));
  hog_cell_histogram #(.NUM_BINS(4), .CELL_SIZE(4), .ACC_W(17)) u4 (
    .clk_in(clk_in), .rst_in(rst_in), .direction_valid_in(v4), .direction(dir), .magnitude(mag),
    .aggregator_ready(r4), .mag_bins(b4), .m_axis_tvalid(t4), .m_axis_tready(tready), .cell_count(c4));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sw_dir = '{32'h0100_0000, 32'h0000_0100, 32'hFF00_0100, 32'h0100_FF00,
               32'hFF00_FF00, 32'hFF00_0000, 32'h8000_0000, 32'h0000_0000};
    sw_bin = '{0, 2, 3, 3, 1, 0, 0, 0};
    {v0, v1, v2, v3, v4} = '0;
    dir = '0;
    mag = '0;
    tready = 1'b1;
    rst_in = 1'b1;
    tick;
    tick;
    chk("rst_ready", 192'(r0), 192'(1));
    chk("rst_tvalid", 192'(t0), 192'(0));
    chk("rst_bins", 192'(b0), 192'(0));
    chk("rst_cells", 192'(c0), 192'(0));
    rst_in = 1'b0;

    // Four identical 45-degree samples into one cell.
    dir = 32'h0300_0300;
    mag = 16'h4000;
    v0 = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    v0 = 1'b0;
    chk("t1_ready_drop", 192'(r0), 192'(0));
    tick;
    chk("t1_tvalid_c1", 192'(t0), 192'(0));
    tick;
    chk("t1_tvalid_c2", 192'(t0), 192'(0));
    tick;
    chk("t1_tvalid_c3", 192'(t0), 192'(1));
    chk("t1_bins", 192'(b0), 192'(96'h000000_000000_010000_000000));
    chk("t1_cells", 192'(c0), 192'(1));
    chk("t1_ready_back", 192'(r0), 192'(1));
    tick;
    chk("t1_tvalid_clear", 192'(t0), 192'(0));

    mag = 16'd1;
    for (int i = 0; i < 8; i++) begin
      dir = sw_dir[i];
      v1 = 1'b1;
      tick;
      v1 = 1'b0;
      tick;
      tick;
      tick;
      chk($sformatf("sweep%0d_tvalid", i), 192'(t1), 192'(1));
      chk($sformatf("sweep%0d_bins", i), 192'(b1), 192'(96'd1 << (sw_bin[i] * 24)));
    end
    tick;
    chk("sweep_cells", 192'(c1), 192'(8));

    dir = 32'h0100_0040;
    v2 = 1'b1;
    tick;
    v2 = 1'b0;
    tick;
    tick;
    tick;
    chk("nb8_14deg", 192'(b2), 192'(1) << 24);
    dir = 32'h0040_0100;
    v2 = 1'b1;
    tick;
    v2 = 1'b0;
    tick;
    tick;
    tick;
    chk("nb8_76deg", 192'(b2), 192'(1) << 72);
    dir = 32'hFF00_0040;
    v2 = 1'b1;
    tick;
    v2 = 1'b0;
    tick;
    tick;
    tick;
    chk("nb8_166deg", 192'(b2), 192'(1) << 168);
    chk("nb8_tvalid", 192'(t2), 192'(1));
    tick;

    // Backpressure: samples carry magnitudes 1,2,3,4 when accepted, 0xFFFF when ignored.
    tready = 1'b0;
    dir = 32'h0100_0000;
    mag = 16'd1;
    v3 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      logic acc_now;
      acc_now = r3;
      tick;
      if (acc_now) mag = mag + 16'd1;
      if (!r3) mag = 16'hFFFF;
      else if (mag == 16'hFFFF) mag = 16'd3;
      if (i == 2) chk("bp_ready_cell1", 192'(r3), 192'(0));
      if (i == 5) chk("bp_first_out", 192'(b3), 192'(3));
      if (i == 5) chk("bp_ready_back", 192'(r3), 192'(1));
      if (i == 7) chk("bp_ready_after4", 192'(r3), 192'(0));
      if (i == 12) chk("bp_hold12", 192'(b3), 192'(3));
    end
    v3 = 1'b0;
    chk("bp_hold_bins", 192'(b3), 192'(3));
    chk("bp_hold_tvalid", 192'(t3), 192'(1));
    chk("bp_ready_low", 192'(r3), 192'(0));
    chk("bp_cells1", 192'(c3), 192'(1));
    tready = 1'b1;
    tick;
    chk("bp_second_tvalid", 192'(t3), 192'(1));
    chk("bp_second_bins", 192'(b3), 192'(7));
    chk("bp_cells2", 192'(c3), 192'(2));
    chk("bp_ready_release", 192'(r3), 192'(1));
    tick;
    chk("bp_drain", 192'(t3), 192'(0));

    dir = 32'h0100_0000;
    mag = 16'hFFFF;
    v4 = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    v4 = 1'b0;
    tick;
    tick;
    tick;
    chk("sat_tvalid", 192'(t4), 192'(1));
    chk("sat_bins", 192'(b4), 192'(68'h1FFFF));
    tick;

    mag = 16'd7;
    v0 = 1'b1;
    tick;
    tick;
    v0 = 1'b0;
    rst_in = 1'b1;
    tick;
    chk("mr_tvalid", 192'(t0), 192'(0));
    chk("mr_bins", 192'(b0), 192'(0));
    chk("mr_cells", 192'(c0), 192'(0));
    chk("mr_ready", 192'(r0), 192'(1));
    rst_in = 1'b0;
    mag = 16'd5;
    v0 = 1'b1;
    for (int i = 0; i < 4; i++) tick;
    v0 = 1'b0;
    tick;
    tick;
    tick;
    chk("mr_out_tvalid", 192'(t0), 192'(1));
    chk("mr_out_bins", 192'(b0), 192'(20));
    chk("mr_out_cells", 192'(c0), 192'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
